seven_segment_serial_display: RTL and testbench
===============================================

Name: seven_segment_serial_display

Overview:
Registered, parametrised successor to the combinational seven-segment display path. It converts a binary value, or the current PC, to decimal using a single shared shift/add-3 engine, one bit per clock. It adds signed two's-complement input, leading-zero blanking, overflow detection and an update/busy handshake with one coalesced pending request. It sits between the CPU I/O register / PC and the board's active-low 7-segment digits, replacing two parallel combinational converters.

Parameters:
DATA_WIDTH, 32, width of value_in and pc_in
DIGITS, 8, number of physical digits driven
PC_DIGITS, 4, number of top digits used in PC mode (1..DIGITS)
BLANK_LEADING, 1, 1 = blank leading zeros in value mode

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
value_in  in  DATA_WIDTH  I/O value to display
value_signed  in  1  1 = treat value_in as two's complement
pc_in  in  DATA_WIDTH  current PC
show_value  in  1  1 = value mode, 0 = PC mode (driven by FLAG_input|FLAG_output)
update  in  1  request a new conversion (level sampled each clock)
busy  out  1  conversion in progress
overflow  out  1  last committed value did not fit
display_out  out  7*DIGITS  digit k at [7k+6:7k], digit 0 = rightmost, active-low segments

Behaviour:
- Reset (synchronous): state IDLE, pending=0, busy=0, overflow=0, every digit = DASH 7'b0111111. Reset mid-conversion aborts; no commit follows.
- Encodings (active-low): 0..9 = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. DASH = 0111111. BLANK = 1111111.
- Internal BCD width: INT_DIGITS = (DATA_WIDTH*3)/10 + 1 digits (10 for 32).
- FSM IDLE -> SHIFT -> COMMIT -> IDLE; busy = (state != IDLE).
- IDLE, update=1 at edge T: sample show_value, value_signed, value_in and pc_in. Load src:
  - value mode: if value_signed and MSB=1, magnitude = -value_in (modulo 2^DATA_WIDTH) and neg=1.
  - PC mode: src = pc_in, neg=0.
  - Clear BCD, bit counter = DATA_WIDTH, go to SHIFT.
- SHIFT: each edge adds 3 to every BCD nibble >= 5, then shifts {bcd, src} left by 1 and decrements the counter. After DATA_WIDTH edges, go to COMMIT.
- COMMIT edge writes display_out and overflow, then returns to IDLE. Latency: display changes at edge T+DATA_WIDTH+1; busy is high for DATA_WIDTH+1 cycles.
- Value mode formatting:
  - overflow = any BCD digit at index >= DIGITS is nonzero, or (neg and digit DIGITS-1 nonzero).
  - On overflow, all digits show DASH.
  - Otherwise digit k shows BCD digit k.
  - If BLANK_LEADING, zeros above the most significant nonzero digit show BLANK; digit 0 always shows a numeral, so value 0 displays "0".
  - neg forces digit DIGITS-1 to DASH, a fixed position.
- PC mode formatting:
  - digits DIGITS-1 .. DIGITS-PC_DIGITS show BCD digits PC_DIGITS-1 .. 0 (low decimal digits of the PC), with no blanking.
  - Remaining digits show DASH; overflow=0.
- Handshake:
  - update while busy (including the COMMIT edge) sets pending=1. Multiple requests coalesce into one.
  - On the edge after COMMIT, if pending=1, clear it and start a new conversion, sampling inputs at that edge.
  - update held high continuously gives back-to-back conversions.
- Inputs are ignored except at start edges; display_out is stable between commits.

Decomposition:
- Package seven_seg_pkg: segment encoding constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK), FSM state enum, function seg_decode(nibble) returning BLANK for nibbles > 9.
- One sub-module, bcd_serial_engine: holds the src/BCD shift register and bit counter. Interface: start, done, bin_in, bcd_out; parametrised by DATA_WIDTH.
- Formatting, handshake and the FSM live in the top.

Test Plan:
- Reset asserted -> all 8 digits 0111111, busy=0, overflow=0. Reset pulsed during SHIFT -> digits return to DASH, no later commit.
- Value mode, unsigned, value_in=12345, one update pulse -> busy high 33 cycles. Digits 4..0 = 1,2,3,4,5 encodings, digits 7..5 = 1111111. value_in=0 -> digit0 = 1000000, rest BLANK.
- value_signed=1, value_in=32'hFFFFFFF9 -> digit7 = 0111111, digit0 = 1111000, others BLANK. value_in = -1234567 -> digit7 DASH, digits 6..0 = 1..7. value_in = -12345678 -> overflow=1, all DASH.
- Unsigned value_in=123456789 -> overflow=1, all digits DASH. Next update with 99999999 -> overflow=0, all eight digits = 9.
- PC mode, pc_in=1234 -> digits 7..4 = 1,2,3,4, digits 3..0 DASH. pc_in=56789 -> digits 7..4 = 6,7,8,9. pc_in=7 -> 0,0,0,7 (no blanking).
- Three update pulses during busy with value_in changed to 42 -> exactly one extra conversion starts on the edge after COMMIT. Final display shows 42; total busy = 2×33 cycles plus the IDLE restart cycle.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared segment encodings, FSM state type and nibble-to-segment decoder for
// the serial seven-segment display path. Segments are active-low, bit 6 = g.
package seven_seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT
   } state_t;

   // Non-decimal nibbles can only appear on a corrupted BCD word; show nothing.
   function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
      case (nibble)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bcd_serial_engine.sv
// Serial binary-to-BCD converter (shift/add-3), one source bit per clock.
// done is high while the final shift is about to happen on the next edge.
module bcd_serial_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int INT_DIGITS = (DATA_WIDTH * 3) / 10 + 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   bin_in,
   output logic                    done,
   output logic [4*INT_DIGITS-1:0] bcd_out
);

   localparam int COUNT_W = $clog2(DATA_WIDTH + 1);

   logic [DATA_WIDTH-1:0]   src;
   logic [4*INT_DIGITS-1:0] bcd;
   logic [4*INT_DIGITS-1:0] adjusted;
   logic [COUNT_W-1:0]      count;

   always_comb begin
      for (int i = 0; i < INT_DIGITS; i++) begin
         adjusted[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      end
   end

   // NOTE: only the counter needs reset; src/bcd are reloaded by every start
   // and are never observed while the counter is idle at zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (start) begin
         src   <= bin_in;
         bcd   <= '0;
         count <= COUNT_W'(DATA_WIDTH);
      end else if (count != '0) begin
         {bcd, src} <= {adjusted[4*INT_DIGITS-2:0], src, 1'b0};
         count      <= count - 1'b1;
      end
   end

   assign done    = (count == COUNT_W'(1));
   assign bcd_out = bcd;

endmodule

// File: rtl/seven_segment_serial_display.sv
// Registered value/PC decimal display: one shared serial BCD engine, signed
// input, leading-zero blanking, overflow flag and a coalescing update handshake.
module seven_segment_serial_display
   import seven_seg_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int DIGITS        = 8,
   parameter int PC_DIGITS     = 4,
   parameter int BLANK_LEADING = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] value_in,
   input  logic                  value_signed,
   input  logic [DATA_WIDTH-1:0] pc_in,
   input  logic                  show_value,
   input  logic                  update,
   output logic                  busy,
   output logic                  overflow,
   output logic [7*DIGITS-1:0]   display_out
);

   localparam int INT_DIGITS = (DATA_WIDTH * 3) / 10 + 1;

   state_t                  state;
   logic                    pending;
   logic                    mode_value;
   logic                    neg;
   logic                    start;
   logic                    eng_done;
   logic [DATA_WIDTH-1:0]   src_in;
   logic [4*INT_DIGITS-1:0] eng_bcd;
   logic [7*DIGITS-1:0]     fmt_display;
   logic                    fmt_overflow;
   logic                    leading;
   logic [3:0]              dig;

   function automatic logic [3:0] bcd_at(input logic [4*INT_DIGITS-1:0] b, input int i);
      if (i >= 0 && i < INT_DIGITS) return b[4*i +: 4];
      return 4'd0;
   endfunction

   assign start = (state == ST_IDLE) && (update || pending);

   always_comb begin
      if (show_value && value_signed && value_in[DATA_WIDTH-1]) src_in = -value_in;
      else if (show_value)                                       src_in = value_in;
      else                                                       src_in = pc_in;
   end

   bcd_serial_engine #(
      .DATA_WIDTH (DATA_WIDTH),
      .INT_DIGITS (INT_DIGITS)
   ) u_engine (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .bin_in  (src_in),
      .done    (eng_done),
      .bcd_out (eng_bcd)
   );

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      fmt_display  = {DIGITS{SEG_DASH}};
      fmt_overflow = 1'b0;
      leading      = (BLANK_LEADING != 0);
      dig          = 4'd0;
      if (mode_value) begin
         for (int i = DIGITS; i < INT_DIGITS; i++) begin
            if (bcd_at(eng_bcd, i) != 4'd0) fmt_overflow = 1'b1;
         end
         if (neg && bcd_at(eng_bcd, DIGITS - 1) != 4'd0) fmt_overflow = 1'b1;
         if (!fmt_overflow) begin
            for (int k = DIGITS - 1; k >= 0; k--) begin
               dig = bcd_at(eng_bcd, k);
               if (leading && dig == 4'd0 && k != 0) begin
                  fmt_display[7*k +: 7] = SEG_BLANK;
               end else begin
                  leading               = 1'b0;
                  fmt_display[7*k +: 7] = seg_decode(dig);
               end
            end
            // The sign occupies a fixed position, not the slot next to the number.
            if (neg) fmt_display[7*(DIGITS-1) +: 7] = SEG_DASH;
         end
      end else begin
         for (int j = 0; j < PC_DIGITS; j++) begin
            fmt_display[7*(DIGITS-PC_DIGITS+j) +: 7] = seg_decode(bcd_at(eng_bcd, j));
         end
      end
   end

   // NOTE: all state and outputs use non-blocking assignments so every register
   // sees pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         pending     <= 1'b0;
         busy        <= 1'b0;
         overflow    <= 1'b0;
         mode_value  <= 1'b0;
         neg         <= 1'b0;
         display_out <= {DIGITS{SEG_DASH}};
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  pending    <= 1'b0;
                  mode_value <= show_value;
                  neg        <= show_value && value_signed && value_in[DATA_WIDTH-1];
                  busy       <= 1'b1;
                  state      <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (update)   pending <= 1'b1;
               if (eng_done) state   <= ST_COMMIT;
            end
            ST_COMMIT: begin
               if (update) pending <= 1'b1;
               display_out <= fmt_display;
               overflow    <= fmt_overflow;
               busy        <= 1'b0;
               state       <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seven_segment_serial_display.sv
// Self-checking bench: directed cases plus randomized conversions compared
// against a decimal-arithmetic reference model of the display formatting.
module tb_seven_segment_serial_display;

   localparam int DW = 32;

   localparam logic [6:0] DASH  = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;

   logic        clock;
   logic        reset;
   logic [31:0] value_in;
   logic        value_signed;
   logic [31:0] pc_in;
   logic        show_value;
   logic        update;
   logic        busy;
   logic        overflow;
   logic [55:0] display_out;

   int compared;
   int mismatched;

   logic [6:0] seg_tab [10];

   seven_segment_serial_display dut (
      .clock        (clock),
      .reset        (reset),
      .value_in     (value_in),
      .value_signed (value_signed),
      .pc_in        (pc_in),
      .show_value   (show_value),
      .update       (update),
      .busy         (busy),
      .overflow     (overflow),
      .display_out  (display_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Expected display from plain decimal arithmetic on the sampled inputs.
   function automatic void model(input logic sv, input logic sg, input logic [31:0] v,
                                 input logic [31:0] pc, output logic [55:0] d, output logic o);
      longint unsigned mag;
      longint unsigned t;
      logic neg;
      d = {8{DASH}};
      o = 1'b0;
      if (sv) begin
         neg = sg && v[31];
         mag = neg ? (64'd4294967296 - 64'(v)) : 64'(v);
         if (mag >= (neg ? 64'd10000000 : 64'd100000000)) begin
            o = 1'b1;
         end else begin
            t = mag;
            for (int k = 0; k < 8; k++) begin
               d[7*k +: 7] = (k == 0 || t != 0) ? seg_tab[int'(t % 10)] : BLANK;
               t = t / 10;
            end
            if (neg) d[55:49] = DASH;
         end
      end else begin
         t = 64'(pc);
         for (int j = 0; j < 4; j++) begin
            d[7*(4+j) +: 7] = seg_tab[int'(t % 10)];
            t = t / 10;
         end
      end
   endfunction

   task automatic run_conv(input string tag, input logic sv, input logic sg,
                           input logic [31:0] v, input logic [31:0] pc);
      logic [55:0] exp_d;
      logic [55:0] prev;
      logic        exp_o;
      int          cnt;
      model(sv, sg, v, pc, exp_d, exp_o);
      prev         = display_out;
      show_value   = sv;
      value_signed = sg;
      value_in     = v;
      pc_in        = pc;
      update       = 1'b1;
      tick();
      update       = 1'b0;
      value_in     = $urandom;
      pc_in        = $urandom;
      value_signed = 1'($urandom_range(0, 1));
      show_value   = 1'($urandom_range(0, 1));
      cnt = 0;
      while (busy && cnt < 100) begin
         if (cnt == DW) check({tag, "_hold"}, 64'(display_out), 64'(prev));
         tick();
         cnt++;
      end
      check({tag, "_busy_cycles"}, 64'(cnt), 64'(DW + 1));
      check({tag, "_display"}, 64'(display_out), 64'(exp_d));
      check({tag, "_overflow"}, 64'(overflow), 64'(exp_o));
   endtask

   initial begin
      logic [55:0] exp_d;
      logic        exp_o;
      int          cnt;
      int          gap;
      logic        sv;
      logic        sg;
      logic [31:0] v;

      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      compared     = 0;
      mismatched   = 0;
      reset        = 1'b1;
      update       = 1'b0;
      value_in     = '0;
      value_signed = 1'b0;
      pc_in        = '0;
      show_value   = 1'b1;
      tick();
      tick();
      check("reset_display", 64'(display_out), 64'({8{DASH}}));
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_overflow", 64'(overflow), 64'd0);
      reset = 1'b0;
      tick();

      run_conv("u12345", 1'b1, 1'b0, 32'd12345, 32'd0);
      run_conv("u0", 1'b1, 1'b0, 32'd0, 32'd0);
      run_conv("s_minus7", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0);
      run_conv("s_minus1234567", 1'b1, 1'b1, -32'sd1234567, 32'd0);
      run_conv("s_minus12345678", 1'b1, 1'b1, -32'sd12345678, 32'd0);
      run_conv("u123456789", 1'b1, 1'b0, 32'd123456789, 32'd0);
      run_conv("u99999999", 1'b1, 1'b0, 32'd99999999, 32'd0);
      run_conv("s_min", 1'b1, 1'b1, 32'h8000_0000, 32'd0);
      run_conv("unsigned_msb", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0);
      run_conv("pc1234", 1'b0, 1'b0, 32'd0, 32'd1234);
      run_conv("pc56789", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd56789);
      run_conv("pc7", 1'b0, 1'b0, 32'd0, 32'd7);

      // Coalescing: three requests during one conversion yield one extra run.
      model(1'b1, 1'b0, 32'd42, 32'd0, exp_d, exp_o);
      show_value   = 1'b1;
      value_signed = 1'b0;
      value_in     = 32'd7;
      update       = 1'b1;
      tick();
      update       = 1'b0;
      value_in     = 32'd42;
      cnt = 0;
      while (busy && cnt < 100) begin
         update = (cnt == 5 || cnt == 10 || cnt == 15);
         tick();
         cnt++;
      end
      update = 1'b0;
      check("coalesce_first_busy", 64'(cnt), 64'(DW + 1));
      check("coalesce_first_display", 64'(display_out), 64'({{7{BLANK}}, seg_tab[7]}));
      gap = 0;
      while (!busy && gap < 10) begin
         tick();
         gap++;
      end
      check("coalesce_idle_gap", 64'(gap), 64'd1);
      cnt = 0;
      while (busy && cnt < 100) begin
         tick();
         cnt++;
      end
      check("coalesce_second_busy", 64'(cnt), 64'(DW + 1));
      check("coalesce_display", 64'(display_out), 64'(exp_d));
      gap = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (busy) gap++;
      end
      check("coalesce_no_third", 64'(gap), 64'd0);

      // Randomized conversions against the reference model.
      for (int n = 0; n < 25; n++) begin
         sv = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = $urandom % 100000000;
            2:       v = $urandom_range(0, 999);
            default: v = -($urandom_range(0, 9999999));
         endcase
         run_conv($sformatf("rand%0d", n), sv, sg, v, $urandom);
      end

      // Reset in the middle of a conversion aborts it with no later commit.
      run_conv("pre_abort", 1'b1, 1'b0, 32'd31415, 32'd0);
      show_value = 1'b1;
      value_in   = 32'd271828;
      update     = 1'b1;
      tick();
      update = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_display", 64'(display_out), 64'({8{DASH}}));
      check("abort_busy", 64'(busy), 64'd0);
      gap = 0;
      for (int i = 0; i < 45; i++) begin
         tick();
         if (busy) gap++;
      end
      check("abort_no_busy", 64'(gap), 64'd0);
      check("abort_no_commit", 64'(display_out), 64'({8{DASH}}));
      check("abort_overflow", 64'(overflow), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
